poly1305_mac_engine: RTL and testbench

//  Self-contained Poly1305 MAC engine: absorbs a 128-bit-lane byte stream, computes (r,s)-keyed tag incl. final
//  mod-p reduction and +s, optionally compares against an expected tag. Successor to the ChaCha/Poly adapter:

---
 rtl/poly1305_mac_engine.sv | 170 +++++++++++++++++
 tb/tb_poly1305_mac_engine.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_mac_engine.sv
// Poly1305 MAC engine: absorbs 16-byte lanes, runs a digit-serial multiply mod 2^130-5,
// then reduces, adds s and optionally compares the tag against an expected value.
module poly1305_mac_engine #(
  parameter int DIGIT_W = 32,
  parameter bit TAG_CMP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         mode_aead,
  input  logic [127:0] r_key,
  input  logic [127:0] s_key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [15:0]  in_keep,
  input  logic         in_last,
  input  logic [127:0] cmp_tag,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         tag_match,
  output logic         busy,
  output logic         err
);

  localparam int CPB = 128 / DIGIT_W;
  localparam int PW  = DIGIT_W + 134;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [130:0] P130  = {3'b011, 128'hffffffff_ffffffff_ffffffff_fffffffb};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_MUL,
    S_FINAL,
    S_DONE
  } state_t;

  state_t       state;
  logic [127:0] r_q;
  logic [127:0] s_q;
  logic         aead_q;
  logic         last_q;
  logic [130:0] acc;
  logic [131:0] h_q;
  logic [130:0] t_q;
  logic [4:0]   dig_cnt;

  assign in_ready = (state == S_ACCEPT);
  assign busy     = (state != S_IDLE);

  // Block value: masked bytes plus the pad bit, and the protocol checks on this beat.
  logic [127:0] masked;
  logic [4:0]   nbytes;
  logic [128:0] blk_m;
  logic         keep_bad;

  // NOTE: every always_comb output gets a value on every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    masked = '0;
    for (int i = 0; i < 16; i++) begin
      masked[8*i +: 8] = in_data[8*i +: 8] & {8{in_keep[i]}};
    end
    nbytes = 5'($countones(in_keep));
    if (aead_q || nbytes == 5'd16) begin
      blk_m = {1'b1, masked};
    end else begin
      blk_m = {1'b0, masked} | (129'd1 << (8 * nbytes));
    end
    keep_bad = ((in_keep & (in_keep + 16'd1)) != 16'd0) ||
               (!aead_q && !in_last && in_keep != 16'hffff);
  end

  // One Horner step over the current r digit, folded twice via 2^130 = 5 so the result stays below 2^131.
  logic [DIGIT_W-1:0] digit;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      fold1;
  logic [130:0]       fold2;

  always_comb begin
    digit = DIGIT_W'(r_q >> (32'(dig_cnt) * DIGIT_W));
    prod  = (PW'(t_q) << DIGIT_W) + PW'(h_q) * PW'(digit);
    fold1 = PW'(prod[129:0]) + ((prod >> 130) << 2) + (prod >> 130);
    fold2 = 131'(PW'(fold1[129:0]) + ((fold1 >> 130) << 2) + (fold1 >> 130));
  end

  // acc < 2^131 < 3p, so two conditional subtracts give the canonical residue.
  logic [130:0] red1;
  logic [130:0] red2;
  logic [127:0] tag_next;

  always_comb begin
    red1     = (acc >= P130) ? acc - P130 : acc;
    red2     = (red1 >= P130) ? red1 - P130 : red1;
    tag_next = red2[127:0] + s_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      r_q       <= '0;
      s_q       <= '0;
      aead_q    <= 1'b0;
      last_q    <= 1'b0;
      acc       <= '0;
      h_q       <= '0;
      t_q       <= '0;
      dig_cnt   <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      tag_match <= 1'b0;
      err       <= 1'b0;
    end else begin
      tag_valid <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              r_q    <= r_key & CLAMP;
              s_q    <= s_key;
              aead_q <= mode_aead;
              acc    <= '0;
              err    <= 1'b0;
              state  <= S_ACCEPT;
            end
          end
          S_ACCEPT: begin
            if (in_valid) begin
              if (keep_bad) err <= 1'b1;
              if (in_keep != 16'd0) begin
                h_q     <= {1'b0, acc} + 132'(blk_m);
                t_q     <= '0;
                dig_cnt <= 5'(CPB - 1);
                last_q  <= in_last;
                state   <= S_MUL;
              end else if (in_last) begin
                state <= S_FINAL;
              end
            end
          end
          S_MUL: begin
            t_q <= fold2;
            if (dig_cnt == 5'd0) begin
              acc   <= fold2;
              state <= last_q ? S_FINAL : S_ACCEPT;
            end else begin
              dig_cnt <= dig_cnt - 5'd1;
            end
          end
          S_FINAL: begin
            acc       <= red2;
            tag       <= tag_next;
            tag_match <= TAG_CMP && (tag_next == cmp_tag);
            tag_valid <= 1'b1;
            state     <= S_DONE;
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly1305_mac_engine.sv
// Randomized bench for poly1305_mac_engine at DIGIT_W = 8, 32 and 128, checked against
// a plain modular-arithmetic Poly1305 model with a scoreboard for every tag pulse.
module tb_poly1305_mac_engine;

  localparam logic [127:0] CLAMP   = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [129:0] P       = {2'b11, 128'hffffffff_ffffffff_ffffffff_fffffffb};
  localparam logic [127:0] RFC_R   = 128'ha806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
  localparam logic [127:0] EMPTY_S = 128'h0123456789abcdef0011223344556677;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_v    [3];
  logic         abort_v    [3];
  logic         mode_v     [3];
  logic [127:0] r_key_v    [3];
  logic [127:0] s_key_v    [3];
  logic         in_valid_v [3];
  logic         in_ready_v [3];
  logic [127:0] in_data_v  [3];
  logic [15:0]  keep_v     [3];
  logic         in_last_v  [3];
  logic [127:0] cmp_v      [3];
  logic [127:0] tag_v      [3];
  logic         tag_valid_v[3];
  logic         tag_match_v[3];
  logic         busy_v     [3];
  logic         err_v      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    poly1305_mac_engine #(
      .DIGIT_W(g == 0 ? 8 : (g == 1 ? 32 : 128)),
      .TAG_CMP(1'b1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .abort    (abort_v[g]),
      .mode_aead(mode_v[g]),
      .r_key    (r_key_v[g]),
      .s_key    (s_key_v[g]),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .in_data  (in_data_v[g]),
      .in_keep  (keep_v[g]),
      .in_last  (in_last_v[g]),
      .cmp_tag  (cmp_v[g]),
      .tag      (tag_v[g]),
      .tag_valid(tag_valid_v[g]),
      .tag_match(tag_match_v[g]),
      .busy     (busy_v[g]),
      .err      (err_v[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  kp;
  } beat_t;

  typedef struct {
    int           k;
    logic [127:0] tag;
    logic         match;
  } exp_t;

  beat_t msg[$];
  exp_t  exp_q[$];

  function automatic int cpb(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic [15:0] cmask(input int n);
    logic [16:0] v;
    v = (17'd1 << n) - 17'd1;
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Poly1305 straight from its definition: h = (h + m) * r mod p per block, tag = h + s mod 2^128.
  function automatic logic [127:0] model_tag(input bit aead, input logic [127:0] rk,
                                             input logic [127:0] sk, input beat_t bq[$]);
    logic [263:0] h;
    logic [263:0] m;
    logic [263:0] r;
    h = '0;
    r = {136'd0, rk & CLAMP};
    foreach (bq[i]) begin
      int n;
      if (bq[i].kp == 16'd0) continue;
      m = '0;
      n = 0;
      for (int b = 0; b < 16; b++) begin
        if (bq[i].kp[b]) begin
          m[8*b +: 8] = bq[i].d[8*b +: 8];
          n++;
        end
      end
      if (aead) m[128] = 1'b1;
      else m[8*n] = 1'b1;
      h = ((h + m) * r) % {134'd0, P};
    end
    return h[127:0] + sk;
  endfunction

  task automatic load_string(input string s);
    msg.delete();
    for (int j = 0; j < (s.len() + 15) / 16; j++) begin
      beat_t bt;
      int    idx;
      bt.d  = '0;
      bt.kp = '0;
      for (int b = 0; b < 16; b++) begin
        idx = 16 * j + b;
        if (idx < s.len()) begin
          bt.d[8*b +: 8] = s[idx];
          bt.kp[b]       = 1'b1;
        end
      end
      msg.push_back(bt);
    end
  endtask

  // Caller sits just after a rising edge; returns just after the edge that transferred the beat
  // (or after the ready gap when chk_gap is set).
  task automatic send_beat(input int k, input beat_t bt, input bit lst, input bit chk_gap);
    int n;
    in_data_v[k]  = bt.d;
    keep_v[k]     = bt.kp;
    in_last_v[k]  = lst;
    in_valid_v[k] = 1'b1;
    n = 0;
    while (!in_ready_v[k] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready_v[k], 1'b1);
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    in_last_v[k]  = 1'b0;
    if (chk_gap && !lst && bt.kp != 16'd0) begin
      n = 0;
      while (!in_ready_v[k] && n < 200) begin
        n++;
        @(posedge clk); #1;
      end
      check("ready_gap", n, cpb(k));
    end
  endtask

  task automatic start_msg(input int k, input bit aead, input logic [127:0] rk,
                           input logic [127:0] sk, input logic [127:0] cmp);
    r_key_v[k]  = rk;
    s_key_v[k]  = sk;
    mode_v[k]   = aead;
    cmp_v[k]    = cmp;
    start_v[k]  = 1'b1;
    @(posedge clk); #1;
    start_v[k]  = 1'b0;
    check("busy_after_start", busy_v[k], 1'b1);
  endtask

  // cmp_mode: 0 = correct tag, 1 = correct tag with bit 0 flipped, 2 = random.
  task automatic run_msg(input int k, input bit aead, input logic [127:0] rk,
                         input logic [127:0] sk, input int cmp_mode);
    logic [127:0] et;
    logic [127:0] cmp;
    int           lat;
    exp_t         e;
    et = model_tag(aead, rk, sk, msg);
    case (cmp_mode)
      0:       cmp = et;
      1:       cmp = et ^ 128'd1;
      default: cmp = {$urandom, $urandom, $urandom, $urandom};
    endcase
    start_msg(k, aead, rk, sk, cmp);
    e.k     = k;
    e.tag   = et;
    e.match = (cmp == et);
    exp_q.push_back(e);
    for (int i = 0; i < msg.size(); i++) begin
      send_beat(k, msg[i], i == msg.size() - 1, 1'b1);
    end
    lat = 1;
    while (!tag_valid_v[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("tag_latency", lat, (msg[msg.size()-1].kp != 16'd0) ? cpb(k) + 2 : 2);
    @(posedge clk); #1;
    check("idle_after_done", busy_v[k], 1'b0);
  endtask

  // Scoreboard: every tag pulse must correspond to an expected message, in order.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (tag_valid_v[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tag_valid inst=%0d: got tag_valid=1 expected 0", k);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("tag_inst", k, e.k);
            check("tag", tag_v[k], e.tag);
            check("tag_match", tag_match_v[k], e.match);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time budget");
    $fatal(1);
  end

  initial begin
    beat_t bt;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; abort_v[k] = 1'b0; mode_v[k] = 1'b0;
      r_key_v[k] = '0; s_key_v[k] = '0; in_valid_v[k] = 1'b0;
      in_data_v[k] = '0; keep_v[k] = '0; in_last_v[k] = 1'b0; cmp_v[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_tag", tag_v[k], '0);
      check("rst_tag_valid", tag_valid_v[k], 1'b0);
      check("rst_tag_match", tag_match_v[k], 1'b0);
      check("rst_busy", busy_v[k], 1'b0);
      check("rst_err", err_v[k], 1'b0);
      check("rst_in_ready", in_ready_v[k], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pin the model against the published vector and the empty-message rule.
    load_string("Cryptographic Forum Research Group");
    check("model_rfc", model_tag(1'b0, RFC_R, RFC_S, msg), RFC_TAG);
    check("rfc_keep_last", msg[2].kp, 16'h0003);

    for (int k = 0; k < 3; k++) begin
      load_string("Cryptographic Forum Research Group");
      run_msg(k, 1'b0, RFC_R, RFC_S, 0);
      check("rfc_tag_literal", tag_v[k], RFC_TAG);
      check("rfc_match", tag_match_v[k], 1'b1);
      run_msg(k, 1'b0, RFC_R, RFC_S, 1);
      check("rfc_flip_match", tag_match_v[k], 1'b0);
      check("rfc_err", err_v[k], 1'b0);
    end

    // Empty message: tag equals s.
    msg.delete();
    bt.d = {$urandom, $urandom, $urandom, $urandom};
    bt.kp = 16'h0000;
    msg.push_back(bt);
    check("model_empty", model_tag(1'b1, RFC_R, EMPTY_S, msg), EMPTY_S);
    for (int k = 0; k < 3; k++) begin
      run_msg(k, 1'b1, RFC_R, EMPTY_S, 0);
      check("empty_tag_literal", tag_v[k], EMPTY_S);
      check("empty_match", tag_match_v[k], 1'b1);
    end

    // r = 0, AEAD, four full beats: tag equals s, ready gap checked per beat.
    for (int k = 0; k < 3; k++) begin
      logic [127:0] sk;
      sk = {$urandom, $urandom, $urandom, $urandom};
      msg.delete();
      for (int j = 0; j < 4; j++) begin
        bt.d  = {$urandom, $urandom, $urandom, $urandom};
        bt.kp = 16'hffff;
        msg.push_back(bt);
      end
      run_msg(k, 1'b1, 128'd0, sk, 0);
      check("r0_tag_is_s", tag_v[k], sk);
    end

    // Non-contiguous keep sets a sticky error; the next start clears it.
    msg.delete();
    bt.d = {$urandom, $urandom, $urandom, $urandom}; bt.kp = 16'h0005; msg.push_back(bt);
    bt.d = {$urandom, $urandom, $urandom, $urandom}; bt.kp = 16'hffff; msg.push_back(bt);
    run_msg(1, 1'b1, RFC_R, RFC_S, 0);
    repeat (3) @(posedge clk);
    #1;
    check("err_noncontig_sticky", err_v[1], 1'b1);
    load_string("Cryptographic Forum Research Group");
    run_msg(1, 1'b0, RFC_R, RFC_S, 0);
    check("err_cleared_by_start", err_v[1], 1'b0);

    // Raw mode partial non-last beat.
    msg.delete();
    bt.d = {$urandom, $urandom, $urandom, $urandom}; bt.kp = 16'h00ff; msg.push_back(bt);
    bt.d = {$urandom, $urandom, $urandom, $urandom}; bt.kp = 16'hffff; msg.push_back(bt);
    run_msg(2, 1'b0, RFC_R, RFC_S, 0);
    check("err_raw_partial", err_v[2], 1'b1);

    // Abort mid-multiply: no tag, back to IDLE, then a clean vector.
    bt.d = {$urandom, $urandom, $urandom, $urandom};
    bt.kp = 16'hffff;
    start_msg(0, 1'b1, RFC_R, RFC_S, '0);
    send_beat(0, bt, 1'b0, 1'b0);
    @(posedge clk); #1;
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    check("abort_idle", busy_v[0], 1'b0);
    check("abort_no_ready", in_ready_v[0], 1'b0);
    repeat (30) @(posedge clk);
    #1;
    load_string("Cryptographic Forum Research Group");
    run_msg(0, 1'b0, RFC_R, RFC_S, 0);
    check("after_abort_tag", tag_v[0], RFC_TAG);

    // Reset mid-multiply: immediate IDLE, outputs cleared, no tag pulse.
    start_msg(0, 1'b1, RFC_R, RFC_S, '0);
    send_beat(0, bt, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("rst_mid_busy", busy_v[0], 1'b0);
    check("rst_mid_tag_valid", tag_valid_v[0], 1'b0);
    check("rst_mid_tag", tag_v[0], '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    load_string("Cryptographic Forum Research Group");
    run_msg(0, 1'b0, RFC_R, RFC_S, 0);
    check("after_rst_tag", tag_v[0], RFC_TAG);

    // Random legal messages across all three digit widths.
    for (int it = 0; it < 24; it++) begin
      int           k;
      int           nb;
      bit           aead;
      logic [127:0] rk;
      logic [127:0] sk;
      k    = int'($urandom_range(2, 0));
      aead = 1'($urandom_range(1, 0));
      nb   = int'($urandom_range(4, 1));
      rk   = {$urandom, $urandom, $urandom, $urandom};
      sk   = {$urandom, $urandom, $urandom, $urandom};
      msg.delete();
      for (int j = 0; j < nb; j++) begin
        bt.d = {$urandom, $urandom, $urandom, $urandom};
        if (j < nb - 1 && !aead) bt.kp = 16'hffff;
        else bt.kp = cmask(int'($urandom_range(16, 0)));
        msg.push_back(bt);
      end
      run_msg(k, aead, rk, sk, int'($urandom_range(2, 0)));
      check("rand_err", err_v[k], 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
